// File: rtl/fb_sdram_reader.sv
// fb_sdram_reader: Wishbone master that streams one framebuffer frame from
// SDRAM, one 32-bit word per classic read cycle, into the write side of the
// dual-clock pixel FIFO. A fetch is started by a frame_start pulse that is
// already synchronous to sys_clk.
module fb_sdram_reader #(
   parameter int          HDISP     = 800,
   parameter int          VDISP     = 480,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic        frame_start,
   output logic        wshb_cyc,
   output logic        wshb_stb,
   output logic        wshb_we,
   output logic [31:0] wshb_adr,
   output logic [3:0]  wshb_sel,
   output logic [2:0]  wshb_cti,
   output logic [1:0]  wshb_bte,
   input  logic        wshb_ack,
   input  logic [31:0] wshb_dat_sm,
   input  logic        wshb_err,
   input  logic        wshb_rty,
   output logic [31:0] fifo_wdata,
   output logic        fifo_write,
   input  logic        fifo_wfull,
   output logic        busy,
   output logic        overrun
);

   localparam int NWORDS = HDISP * VDISP;
   localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

   typedef enum logic [1:0] {
      IDLE,
      CHECK,
      REQ,
      LAST
   } state_t;

   state_t            state,        state_next;
   logic              cyc_reg,      cyc_next;
   logic              stb_reg,      stb_next;
   logic [31:0]       adr_reg,      adr_next;
   logic [31:0]       wdata_reg,    wdata_next;
   logic              write_reg,    write_next;
   logic              busy_reg,     busy_next;
   logic              overrun_reg,  overrun_next;
   logic [IDX_W-1:0]  idx,          idx_next;
   logic              restart_pend, restart_pend_next;
   logic              restart;

   // Constant bus qualifiers: single-word classic reads with all byte lanes.
   assign wshb_we    = 1'b0;
   assign wshb_sel   = 4'hF;
   assign wshb_cti   = 3'b000;
   assign wshb_bte   = 2'b00;
   assign wshb_cyc   = cyc_reg;
   assign wshb_stb   = stb_reg;
   assign wshb_adr   = adr_reg;
   assign fifo_wdata = wdata_reg;
   assign fifo_write = write_reg;
   assign busy       = busy_reg;
   assign overrun    = overrun_reg;

   // A restart request may be pending from earlier or arrive this very cycle.
   assign restart = restart_pend | frame_start;

   // State and every bus/FIFO output are registered; reset kills any
   // outstanding cycle immediately so no half-finished read can write the FIFO.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state        <= IDLE;
         cyc_reg      <= 1'b0;
         stb_reg      <= 1'b0;
         adr_reg      <= BASE_ADDR;
         wdata_reg    <= 32'h0;
         write_reg    <= 1'b0;
         busy_reg     <= 1'b0;
         overrun_reg  <= 1'b0;
         idx          <= '0;
         restart_pend <= 1'b0;
      end else begin
         state        <= state_next;
         cyc_reg      <= cyc_next;
         stb_reg      <= stb_next;
         adr_reg      <= adr_next;
         wdata_reg    <= wdata_next;
         write_reg    <= write_next;
         busy_reg     <= busy_next;
         overrun_reg  <= overrun_next;
         idx          <= idx_next;
         restart_pend <= restart_pend_next;
      end
   end

   // Next-state and next-output logic; only one read is ever in flight, so a
   // non-full FIFO at issue time always has room for the returned word.
   always_comb begin
      state_next        = state;
      cyc_next          = cyc_reg;
      stb_next          = stb_reg;
      adr_next          = adr_reg;
      wdata_next        = wdata_reg;
      write_next        = 1'b0;
      busy_next         = busy_reg;
      overrun_next      = 1'b0;
      idx_next          = idx;
      restart_pend_next = restart_pend;

      case (state)
         IDLE: begin
            if (frame_start) begin
               idx_next          = '0;
               busy_next         = 1'b1;
               restart_pend_next = 1'b0;
               state_next        = CHECK;
            end
         end

         CHECK: begin
            if (frame_start) begin
               overrun_next = 1'b1;
            end
            if (restart_pend) begin
               idx_next          = '0;
               restart_pend_next = 1'b0;
            end else begin
               if (frame_start) begin
                  restart_pend_next = 1'b1;
               end
               if (!fifo_wfull) begin
                  cyc_next   = 1'b1;
                  stb_next   = 1'b1;
                  adr_next   = BASE_ADDR + (32'(idx) << 2);
                  state_next = REQ;
               end
            end
         end

         REQ: begin
            if (frame_start) begin
               overrun_next = 1'b1;
            end
            if (wshb_ack) begin
               cyc_next   = 1'b0;
               stb_next   = 1'b0;
               wdata_next = wshb_dat_sm;
               write_next = 1'b1;
               if (restart) begin
                  idx_next          = '0;
                  restart_pend_next = 1'b0;
                  state_next        = CHECK;
               end else if (idx == LAST_IDX) begin
                  busy_next  = 1'b0;
                  state_next = LAST;
               end else begin
                  idx_next   = idx + IDX_W'(1);
                  state_next = CHECK;
               end
            end else if (wshb_err || wshb_rty) begin
               cyc_next   = 1'b0;
               stb_next   = 1'b0;
               state_next = CHECK;
               if (restart) begin
                  idx_next          = '0;
                  restart_pend_next = 1'b0;
               end
            end else if (frame_start) begin
               restart_pend_next = 1'b1;
            end
         end

         LAST: begin
            if (frame_start) begin
               idx_next          = '0;
               busy_next         = 1'b1;
               restart_pend_next = 1'b0;
               state_next        = CHECK;
            end else begin
               busy_next  = 1'b0;
               state_next = IDLE;
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_fb_sdram_reader.sv
// Testbench for fb_sdram_reader on a scaled-down 4x2 frame at a non-zero base
// address, with a behavioural Wishbone slave and a bus/FIFO monitor.
module tb_fb_sdram_reader;

   localparam logic [31:0] BASE = 32'h0010_0000;
   localparam logic [31:0] KEY  = 32'h5A5A_0000;

   logic        sys_clk = 1'b0;
   logic        sys_rst;
   logic        frame_start;
   logic        wshb_cyc, wshb_stb, wshb_we;
   logic [31:0] wshb_adr;
   logic [3:0]  wshb_sel;
   logic [2:0]  wshb_cti;
   logic [1:0]  wshb_bte;
   logic        wshb_ack, wshb_err, wshb_rty;
   logic [31:0] wshb_dat_sm;
   logic [31:0] fifo_wdata;
   logic        fifo_write, fifo_wfull;
   logic        busy, overrun;

   int          n_compared   = 0;
   int          n_mismatched = 0;
   int          err_hits     = 0;
   int          err_limit;
   logic [31:0] err_adr;
   logic        prev_stb;
   logic [31:0] req_q[$];
   logic [31:0] wr_q[$];

   fb_sdram_reader #(
      .HDISP(4),
      .VDISP(2),
      .BASE_ADDR(BASE)
   ) dut (
      .sys_clk(sys_clk),
      .sys_rst(sys_rst),
      .frame_start(frame_start),
      .wshb_cyc(wshb_cyc),
      .wshb_stb(wshb_stb),
      .wshb_we(wshb_we),
      .wshb_adr(wshb_adr),
      .wshb_sel(wshb_sel),
      .wshb_cti(wshb_cti),
      .wshb_bte(wshb_bte),
      .wshb_ack(wshb_ack),
      .wshb_dat_sm(wshb_dat_sm),
      .wshb_err(wshb_err),
      .wshb_rty(wshb_rty),
      .fifo_wdata(fifo_wdata),
      .fifo_write(fifo_write),
      .fifo_wfull(fifo_wfull),
      .busy(busy),
      .overrun(overrun)
   );

   // 100 MHz system clock
   always #5 sys_clk = ~sys_clk;

   // Slave: answers a strobe seen on a falling edge so the DUT samples the
   // response on the following rising edge; data is the address xor KEY.
   initial begin
      wshb_ack    = 1'b0;
      wshb_err    = 1'b0;
      wshb_rty    = 1'b0;
      wshb_dat_sm = 32'h0;
      forever begin
         @(negedge sys_clk);
         wshb_ack = 1'b0;
         wshb_err = 1'b0;
         if (wshb_cyc && wshb_stb) begin
            if (err_hits < err_limit && wshb_adr == err_adr) begin
               wshb_err = 1'b1;
               err_hits++;
            end else begin
               wshb_ack    = 1'b1;
               wshb_dat_sm = wshb_adr ^ KEY;
            end
         end
      end
   end

   // Monitor: logs each new request address and each FIFO write word.
   initial begin
      prev_stb = 1'b0;
      forever begin
         @(negedge sys_clk);
         if (wshb_stb && !prev_stb) req_q.push_back(wshb_adr);
         prev_stb = wshb_stb;
         if (fifo_write) wr_q.push_back(fifo_wdata);
      end
   end

   task automatic tick();
      @(negedge sys_clk);
      #1;
   endtask

   task automatic start_frame();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
   endtask

   task automatic wait_reqs(input int n);
      int cnt = 0;
      while (req_q.size() < n && cnt < 400) begin
         tick();
         cnt++;
      end
      n_compared++;
      if (req_q.size() < n) begin
         n_mismatched++;
         $display("[TB] FAIL wait_reqs: got %0d requests, need %0d", req_q.size(), n);
      end
   endtask

   task automatic wait_writes(input int n);
      int cnt = 0;
      while (wr_q.size() < n && cnt < 400) begin
         tick();
         cnt++;
      end
      n_compared++;
      if (wr_q.size() < n) begin
         n_mismatched++;
         $display("[TB] FAIL wait_writes: got %0d writes, need %0d", wr_q.size(), n);
      end
   endtask

   // Reset values and constant bus qualifiers.
   task automatic test_reset();
      sys_rst     = 1'b1;
      frame_start = 1'b0;
      fifo_wfull  = 1'b0;
      err_limit   = 0;
      err_adr     = 32'h0;
      repeat (3) tick();
      n_compared++;
      if ({wshb_cyc, wshb_stb, fifo_write, busy, overrun} !== 5'b0) begin
         n_mismatched++;
         $display("[TB] FAIL reset_ctrl: got %b want 00000", {wshb_cyc, wshb_stb, fifo_write, busy, overrun});
      end
      n_compared++;
      if (wshb_adr !== BASE) begin
         n_mismatched++;
         $display("[TB] FAIL reset_adr: got %h want %h", wshb_adr, BASE);
      end
      n_compared++;
      if (fifo_wdata !== 32'h0) begin
         n_mismatched++;
         $display("[TB] FAIL reset_wdata: got %h want 0", fifo_wdata);
      end
      n_compared++;
      if ({wshb_we, wshb_sel, wshb_cti, wshb_bte} !== 10'b0_1111_000_00) begin
         n_mismatched++;
         $display("[TB] FAIL bus_consts: got %b want 0111100000", {wshb_we, wshb_sel, wshb_cti, wshb_bte});
      end
      sys_rst = 1'b0;
      repeat (3) tick();
      n_compared++;
      if (wshb_stb !== 1'b0 || busy !== 1'b0) begin
         n_mismatched++;
         $display("[TB] FAIL idle_after_reset: got stb=%b busy=%b want 0 0", wshb_stb, busy);
      end
   endtask

   // Full 8-word frame: addresses, data, busy and bus idle at the end.
   task automatic test_basic_frame();
      int s = req_q.size();
      int w = wr_q.size();
      start_frame();
      n_compared++;
      if (busy !== 1'b1) begin
         n_mismatched++;
         $display("[TB] FAIL basic_busy_high: got %b want 1", busy);
      end
      wait_writes(w + 8);
      repeat (4) tick();
      n_compared++;
      if (req_q.size() - s != 8 || wr_q.size() - w != 8) begin
         n_mismatched++;
         $display("[TB] FAIL basic_counts: got req=%0d wr=%0d want 8 8", req_q.size() - s, wr_q.size() - w);
      end
      for (int i = 0; i < 8; i++) begin
         n_compared++;
         if (req_q[s + i] !== BASE + 32'(4 * i)) begin
            n_mismatched++;
            $display("[TB] FAIL basic_adr[%0d]: got %h want %h", i, req_q[s + i], BASE + 32'(4 * i));
         end
         n_compared++;
         if (wr_q[w + i] !== ((BASE + 32'(4 * i)) ^ KEY)) begin
            n_mismatched++;
            $display("[TB] FAIL basic_data[%0d]: got %h want %h", i, wr_q[w + i], (BASE + 32'(4 * i)) ^ KEY);
         end
      end
      n_compared++;
      if (busy !== 1'b0 || wshb_cyc !== 1'b0) begin
         n_mismatched++;
         $display("[TB] FAIL basic_end_idle: got busy=%b cyc=%b want 0 0", busy, wshb_cyc);
      end
   endtask

   // FIFO full for 20 cycles after the third word stalls issue at 0xC.
   task automatic test_fifo_full();
      int s = req_q.size();
      int w = wr_q.size();
      int rc;
      start_frame();
      wait_writes(w + 3);
      fifo_wfull = 1'b1;
      rc = req_q.size();
      repeat (20) tick();
      n_compared++;
      if (req_q.size() != rc || wshb_stb !== 1'b0 || rc - s != 3) begin
         n_mismatched++;
         $display("[TB] FAIL full_hold: got reqs=%0d stb=%b want 3 0", req_q.size() - s, wshb_stb);
      end
      fifo_wfull = 1'b0;
      tick();
      n_compared++;
      if (wshb_stb !== 1'b1 || wshb_adr !== BASE + 32'hC) begin
         n_mismatched++;
         $display("[TB] FAIL full_resume: got stb=%b adr=%h want 1 %h", wshb_stb, wshb_adr, BASE + 32'hC);
      end
      wait_writes(w + 8);
      repeat (4) tick();
      n_compared++;
      if (wr_q.size() - w != 8) begin
         n_mismatched++;
         $display("[TB] FAIL full_count: got %0d writes want 8", wr_q.size() - w);
      end
      for (int i = 0; i < 8; i++) begin
         n_compared++;
         if (wr_q[w + i] !== ((BASE + 32'(4 * i)) ^ KEY)) begin
            n_mismatched++;
            $display("[TB] FAIL full_data[%0d]: got %h want %h", i, wr_q[w + i], (BASE + 32'(4 * i)) ^ KEY);
         end
      end
   endtask

   // Error on the 0x8 request: retried once, single FIFO write of ack data.
   task automatic test_err_retry();
      int s = req_q.size();
      int w = wr_q.size();
      logic [31:0] exp_adr [9];
      exp_adr = '{32'h0, 32'h4, 32'h8, 32'h8, 32'hC, 32'h10, 32'h14, 32'h18, 32'h1C};
      err_adr   = BASE + 32'h8;
      err_limit = err_hits + 1;
      start_frame();
      wait_writes(w + 8);
      repeat (4) tick();
      n_compared++;
      if (req_q.size() - s != 9 || wr_q.size() - w != 8) begin
         n_mismatched++;
         $display("[TB] FAIL err_counts: got req=%0d wr=%0d want 9 8", req_q.size() - s, wr_q.size() - w);
      end
      for (int i = 0; i < 9; i++) begin
         n_compared++;
         if (req_q[s + i] !== BASE + exp_adr[i]) begin
            n_mismatched++;
            $display("[TB] FAIL err_adr[%0d]: got %h want %h", i, req_q[s + i], BASE + exp_adr[i]);
         end
      end
      n_compared++;
      if (wr_q[w + 2] !== ((BASE + 32'h8) ^ KEY) || wr_q[w + 3] !== ((BASE + 32'hC) ^ KEY)) begin
         n_mismatched++;
         $display("[TB] FAIL err_data: got %h %h want %h %h", wr_q[w + 2], wr_q[w + 3], (BASE + 32'h8) ^ KEY, (BASE + 32'hC) ^ KEY);
      end
   endtask

   // frame_start during word 5 restarts the fetch from pixel 0.
   task automatic test_overrun();
      int s = req_q.size();
      int w = wr_q.size();
      start_frame();
      wait_reqs(s + 5);
      n_compared++;
      if (wshb_adr !== BASE + 32'h10 || wshb_stb !== 1'b1) begin
         n_mismatched++;
         $display("[TB] FAIL ovr_word5_adr: got %h stb=%b want %h 1", wshb_adr, wshb_stb, BASE + 32'h10);
      end
      start_frame();
      n_compared++;
      if (overrun !== 1'b1 || fifo_write !== 1'b1 || fifo_wdata !== ((BASE + 32'h10) ^ KEY)) begin
         n_mismatched++;
         $display("[TB] FAIL ovr_pulse: got ovr=%b wr=%b data=%h want 1 1 %h", overrun, fifo_write, fifo_wdata, (BASE + 32'h10) ^ KEY);
      end
      tick();
      n_compared++;
      if (overrun !== 1'b0 || busy !== 1'b1) begin
         n_mismatched++;
         $display("[TB] FAIL ovr_one_cycle: got ovr=%b busy=%b want 0 1", overrun, busy);
      end
      wait_writes(w + 13);
      repeat (4) tick();
      n_compared++;
      if (req_q.size() - s != 13 || wr_q.size() - w != 13) begin
         n_mismatched++;
         $display("[TB] FAIL ovr_counts: got req=%0d wr=%0d want 13 13", req_q.size() - s, wr_q.size() - w);
      end
      n_compared++;
      if (req_q[s + 5] !== BASE || req_q[s + 12] !== BASE + 32'h1C) begin
         n_mismatched++;
         $display("[TB] FAIL ovr_restart_adr: got %h %h want %h %h", req_q[s + 5], req_q[s + 12], BASE, BASE + 32'h1C);
      end
      n_compared++;
      if (wr_q[w + 5] !== (BASE ^ KEY) || busy !== 1'b0) begin
         n_mismatched++;
         $display("[TB] FAIL ovr_restart_data: got %h busy=%b want %h 0", wr_q[w + 5], busy, BASE ^ KEY);
      end
   endtask

   // frame_start right as the frame completes starts a new one cleanly.
   task automatic test_back_to_back();
      int s = req_q.size();
      int w = wr_q.size();
      start_frame();
      wait_writes(w + 8);
      start_frame();
      n_compared++;
      if (overrun !== 1'b0 || busy !== 1'b1) begin
         n_mismatched++;
         $display("[TB] FAIL b2b_start: got ovr=%b busy=%b want 0 1", overrun, busy);
      end
      wait_writes(w + 16);
      repeat (4) tick();
      n_compared++;
      if (req_q.size() - s != 16 || req_q[s + 8] !== BASE || req_q[s + 15] !== BASE + 32'h1C) begin
         n_mismatched++;
         $display("[TB] FAIL b2b_reqs: got n=%0d adr8=%h want 16 %h", req_q.size() - s, req_q[s + 8], BASE);
      end
   endtask

   // Asynchronous reset with a strobe outstanding: no write, bus stays idle.
   task automatic test_reset_mid();
      int s = req_q.size();
      int w = wr_q.size();
      start_frame();
      wait_reqs(s + 3);
      #2;
      sys_rst = 1'b1;
      #1;
      n_compared++;
      if (wshb_cyc !== 1'b0 || wshb_stb !== 1'b0) begin
         n_mismatched++;
         $display("[TB] FAIL rst_async_drop: got cyc=%b stb=%b want 0 0", wshb_cyc, wshb_stb);
      end
      tick();
      n_compared++;
      if (fifo_write !== 1'b0 || busy !== 1'b0 || wshb_adr !== BASE) begin
         n_mismatched++;
         $display("[TB] FAIL rst_values: got wr=%b busy=%b adr=%h want 0 0 %h", fifo_write, busy, wshb_adr, BASE);
      end
      sys_rst = 1'b0;
      repeat (10) tick();
      n_compared++;
      if (req_q.size() - s != 3 || wr_q.size() - w != 2 || wshb_cyc !== 1'b0) begin
         n_mismatched++;
         $display("[TB] FAIL rst_quiet: got req=%0d wr=%0d cyc=%b want 3 2 0", req_q.size() - s, wr_q.size() - w, wshb_cyc);
      end
   endtask

   // Sequence of scenarios followed by the summary.
   initial begin
      test_reset();
      test_basic_frame();
      test_fifo_full();
      test_err_retry();
      test_overrun();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
